revo_word_receiver: RTL and testbench
=====================================

# revo_word_receiver

Receive-side counterpart of the 509 MHz clock/revolution-marker transmitter. Consumes the deserialized 8-bit revo-line words on the word clock, finds the 0→1 revo edge at bit granularity, and confirms that edges recur every REVO_PERIOD words. Once confirmed, it flywheels a one-cycle revo strobe aligned to the marker and reports the bit phase plus error counts. It sits directly behind the input deserializer, in the word-clock domain.

## Interface
- WIDTH, 8, bits per deserialized word; MSB is the earliest bit in time
- REVO_PERIOD, 1280, expected words between revo edges
- MIN_ONES, 4, consecutive 1 bits (starting at the edge) needed to qualify an edge; 1..WIDTH
- LOCK_COUNT, 4, consecutive on-time, same-phase edges needed to lock
- UNLOCK_MISSES, 3, consecutive bad revo slots that drop lock
- clock  in  1  word clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- word_in  in  WIDTH  deserialized revo-line word, one per clock
- revo_strobe  out  1  one-cycle pulse per revo slot
- locked  out  1  high while in LOCKED
- bit_phase  out  3  edge offset from the word MSB (0..WIDTH-1), captured at first candidate
- revo_count  out  16  strobes since reset; wraps 65535→0
- error_count  out  16  unexpected, missing or wrong-phase edges while LOCKED; saturates at 65535

## Operation
- Pipeline: d1<=word_in, d2<=d1, d3<=d2. Edge search runs on the 3W window {d3,d2,d1} and evaluates the word in d2.
- An edge at offset k (0..WIDTH-1) in d2 requires: the bit immediately before it is 0, and the MIN_ONES bits starting at it are 1. These bits may span into d3 and d1.
- If several offsets qualify, the lowest k wins. The result is edge_hit and edge_k.
- States: SEARCH, CONFIRM, LOCKED. A slot counter `cnt` ranges 0..REVO_PERIOD-1.
- SEARCH:
  - on edge_hit: bit_phase<=edge_k, cnt<=REVO_PERIOD-1, conf<=1, go to CONFIRM.
- CONFIRM:
  - cnt decrements each clock.
  - At cnt==0, if edge_hit and edge_k==bit_phase: conf++, cnt reloads. If conf reaches LOCK_COUNT, go to LOCKED and assert revo_strobe this cycle.
  - At cnt==0 with no matching edge: go to SEARCH.
  - edge_hit with cnt≠0, or with the wrong phase: restart CONFIRM using this edge (new bit_phase, conf<=1, cnt reloads).
- LOCKED:
  - cnt decrements and reloads at 0. At cnt==0 revo_strobe asserts unconditionally (flywheel).
  - A matching edge at cnt==0 clears miss_run.
  - A missing or wrong-phase edge at cnt==0: error_count++, miss_run++.
  - edge_hit with cnt≠0: error_count++. No strobe, no resync, miss_run unchanged.
  - When miss_run reaches UNLOCK_MISSES: go to SEARCH, locked<=0. error_count is kept.
- revo_count increments on every revo_strobe.

## Timing
- Reset value of every output and internal register is 0; state is SEARCH.
- Reset has priority over every simultaneous event.
- An edge present in word_in at cycle n is evaluated at cycle n+2; registered outputs change at n+3.
- revo_strobe, locked and the counters are all registered and change together.
- A locked edge's revo_strobe appears 3 clocks after its word enters.
- Steady state: revo_strobe has a period of exactly REVO_PERIOD clocks and a width of 1 clock.
- Lock is achieved at the LOCK_COUNT-th edge, (LOCK_COUNT-1)·REVO_PERIOD clocks after the first.
- Reset asserted mid-CONFIRM or mid-LOCKED: state returns to SEARCH and all counters clear on the next edge.
- bit_phase changes only in SEARCH/CONFIRM. It holds while LOCKED.

## Structure
- Shared package holds:
  - the state enum (SEARCH, CONFIRM, LOCKED)
  - the defaults REVO_PERIOD=1280 and WIDTH=8, shared with the transmitter
  - a function for the bit-reversal-free MSB-first offset convention
- Sub-module revo_edge_finder holds the d1..d3 pipeline and the priority encoder. Its outputs are edge_hit and edge_k.
- The top level holds the state machine and counters.

## Test plan
- Transmitter pattern (8'hFF every 1280 words, else 8'h00), offset 0 → locked rises with the 4th edge; bit_phase=0; strobes spaced 1280 clocks; error_count=0.
- Same pattern shifted by 3 bits (words 8'h1F, 8'hE0) → bit_phase=3; lock as above; strobe 3 clocks after the word holding the edge.
- Locked, then one revo word forced to 8'h00 → strobe still fires; error_count=1; locked stays 1. Three consecutive misses → locked=0 after the 3rd slot; error_count=3.
- Locked, then a spurious 8'h0F at slot 600 → error_count=1; no extra strobe; strobe period unchanged.
- CONFIRM with the 3rd edge arriving 1279 words after the 2nd → CONFIRM restarts from that edge; lock occurs 3 periods later.
- Reset pulsed for 1 clock while locked → all outputs 0 next clock; relock after 4 edges.

Source files
------------

// File: rtl/revo_word_receiver_pkg.sv
// revo_word_receiver_pkg
//   Shared definitions for the revolution-marker receive path.
//   - state_t              : receiver state machine encoding
//   - DEFAULT_WIDTH        : bits per deserialized word (shared with the transmitter)
//   - DEFAULT_REVO_PERIOD  : words between revo edges (shared with the transmitter)
//   - win_bit()            : maps a time-ordered bit position in a three-word
//                            window to its vector index (MSB = earliest bit)
package revo_word_receiver_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_REVO_PERIOD = 1280;

  // The window is {d3, d2, d1} with d3 the oldest word. Within each word the
  // MSB arrived first, so time position t (0 = earliest bit of d3) sits at
  // vector index 3*width-1-t. No bit reversal is ever needed.
  function automatic int win_bit(input int width, input int t);
    return 3 * width - 1 - t;
  endfunction

endpackage

// File: rtl/revo_word_receiver_edge_finder.sv
// revo_edge_finder
//   Three-word delay line behind the deserializer plus a priority encoder that
//   looks for a 0->1 revo edge inside the middle word (d2).
//   Ports:
//     clock     in   word clock
//     reset     in   synchronous, active-high; clears the delay line
//     word_in   in   deserialized word, MSB earliest in time
//     edge_hit  out  an edge qualifies somewhere in d2 (combinational)
//     edge_k    out  lowest qualifying offset from the d2 MSB (combinational)
module revo_edge_finder
  import revo_word_receiver_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MIN_ONES = 4,
  parameter int K_W      = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  output logic             edge_hit,
  output logic [K_W-1:0]   edge_k
);

  logic [WIDTH-1:0]   d1;
  logic [WIDTH-1:0]   d2;
  logic [WIDTH-1:0]   d3;
  logic [3*WIDTH-1:0] win;

  always_ff @(posedge clock) begin
    if (reset) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else begin
      d1 <= word_in;
      d2 <= d1;
      d3 <= d2;
    end
  end

  assign win = {d3, d2, d1};

  // Offset k in d2 is time position WIDTH+k. The preceding bit may live in d3
  // (k = 0) and the run of ones may spill into d1. Scanning from the highest
  // offset down lets the lowest qualifying offset overwrite the result last.
  always_comb begin
    logic qual;
    qual     = 1'b0;
    edge_hit = 1'b0;
    edge_k   = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      qual = ~win[win_bit(WIDTH, WIDTH + k - 1)];
      for (int j = 0; j < MIN_ONES; j++) begin
        qual = qual & win[win_bit(WIDTH, WIDTH + k + j)];
      end
      if (qual) begin
        edge_hit = 1'b1;
        edge_k   = K_W'(k);
      end
    end
  end

endmodule

// File: rtl/revo_word_receiver.sv
// revo_word_receiver
//   Finds the revo marker edge in the deserialized revo-line stream, confirms
//   that it recurs every REVO_PERIOD words at a fixed bit phase, then flywheels
//   a one-cycle revo strobe aligned to the marker.
//   Ports:
//     clock        in   word clock; everything runs on its rising edge
//     reset        in   synchronous, active-high
//     word_in      in   deserialized revo-line word, MSB earliest
//     revo_strobe  out  one-cycle pulse per revo slot while locked
//     locked       out  high while in LOCKED
//     bit_phase    out  edge offset from the word MSB, frozen while locked
//     revo_count   out  strobes since reset, wraps
//     error_count  out  bad/missing/unexpected edges seen while locked, saturates
//   Every output is registered; an edge in word_in shows up on the outputs
//   three clocks later.
module revo_word_receiver
  import revo_word_receiver_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int REVO_PERIOD   = DEFAULT_REVO_PERIOD,
  parameter int MIN_ONES      = 4,
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_MISSES = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         word_in,
  output logic                     revo_strobe,
  output logic                     locked,
  output logic [$clog2(WIDTH)-1:0] bit_phase,
  output logic [15:0]              revo_count,
  output logic [15:0]              error_count
);

  localparam int K_W    = $clog2(WIDTH);
  localparam int CNT_W  = $clog2(REVO_PERIOD);
  localparam int CONF_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_MISSES + 1);

  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(REVO_PERIOD - 1);
  localparam logic [CONF_W-1:0] CONF_LOCK  = CONF_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(UNLOCK_MISSES);

  logic              edge_hit;
  logic [K_W-1:0]    edge_k;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CONF_W-1:0] conf;
  logic [MISS_W-1:0] miss_run;

  logic              slot;
  logic              phase_match;
  logic [CONF_W-1:0] conf_next;
  logic [MISS_W-1:0] miss_next;
  logic [15:0]       error_bumped;

  revo_edge_finder #(
    .WIDTH    (WIDTH),
    .MIN_ONES (MIN_ONES),
    .K_W      (K_W)
  ) u_edge_finder (
    .clock    (clock),
    .reset    (reset),
    .word_in  (word_in),
    .edge_hit (edge_hit),
    .edge_k   (edge_k)
  );

  // slot marks the word where the next revo edge is due.
  assign slot         = (cnt == '0);
  assign phase_match  = edge_hit && (edge_k == bit_phase);
  assign conf_next    = conf + CONF_W'(1);
  assign miss_next    = miss_run + MISS_W'(1);
  assign error_bumped = (error_count == 16'hFFFF) ? error_count : error_count + 16'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= SEARCH;
      cnt         <= '0;
      conf        <= '0;
      miss_run    <= '0;
      revo_strobe <= 1'b0;
      locked      <= 1'b0;
      bit_phase   <= '0;
      revo_count  <= '0;
      error_count <= '0;
    end else begin
      revo_strobe <= 1'b0;
      case (state)
        SEARCH: begin
          if (edge_hit) begin
            bit_phase <= edge_k;
            cnt       <= CNT_RELOAD;
            conf      <= CONF_W'(1);
            state     <= CONFIRM;
          end
        end

        CONFIRM: begin
          if (slot && phase_match) begin
            cnt  <= CNT_RELOAD;
            conf <= conf_next;
            if (conf_next == CONF_LOCK) begin
              state       <= LOCKED;
              locked      <= 1'b1;
              miss_run    <= '0;
              revo_strobe <= 1'b1;
              revo_count  <= revo_count + 16'd1;
            end
          end else if (edge_hit) begin
            // Early, late or wrong-phase edge: start confirming from it.
            bit_phase <= edge_k;
            cnt       <= CNT_RELOAD;
            conf      <= CONF_W'(1);
          end else if (slot) begin
            state <= SEARCH;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        LOCKED: begin
          if (slot) begin
            // Flywheel: the strobe fires whether or not the edge showed up.
            cnt         <= CNT_RELOAD;
            revo_strobe <= 1'b1;
            revo_count  <= revo_count + 16'd1;
            if (phase_match) begin
              miss_run <= '0;
            end else begin
              error_count <= error_bumped;
              if (miss_next == MISS_LIMIT) begin
                state    <= SEARCH;
                locked   <= 1'b0;
                miss_run <= '0;
              end else begin
                miss_run <= miss_next;
              end
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
            // An edge between slots is only counted; timing is not disturbed.
            if (edge_hit) begin
              error_count <= error_bumped;
            end
          end
        end

        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_revo_word_receiver.sv
// tb_revo_word_receiver
//   Drives revo-line word streams into revo_word_receiver and compares every
//   cycle against a time-based reference model, plus directed checks of the
//   lock timing, strobe spacing and error counts for each scenario.
module tb_revo_word_receiver;

  localparam int W        = 8;
  localparam int P        = 1280;
  localparam int MIN_ONES = 4;
  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 3;
  localparam int OUT_W    = 1 + 1 + 3 + 16 + 16;

  // ---------------------------------------------------------------- clock/reset
  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] word_in;
  logic         revo_strobe;
  logic         locked;
  logic [2:0]   bit_phase;
  logic [15:0]  revo_count;
  logic [15:0]  error_count;

  always #5 clock = ~clock;

  revo_word_receiver #(
    .WIDTH         (W),
    .REVO_PERIOD   (P),
    .MIN_ONES      (MIN_ONES),
    .LOCK_COUNT    (LOCK_N),
    .UNLOCK_MISSES (UNLOCK_N)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .word_in     (word_in),
    .revo_strobe (revo_strobe),
    .locked      (locked),
    .bit_phase   (bit_phase),
    .revo_count  (revo_count),
    .error_count (error_count)
  );

  // ---------------------------------------------------------------- bookkeeping
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int strobe_ticks[$];
  int edge_ticks[$];
  logic [OUT_W-1:0] exp_q[$];

  // ---------------------------------------------------------------- reference model
  // Slot timing is kept as an absolute cycle number rather than a down-counter.
  int           m_mode;   // 0 search, 1 confirm, 2 locked
  int           m_next;
  int           m_conf;
  int           m_miss;
  int           m_phase;
  int           m_revo;
  int           m_err;
  bit           m_strobe;
  bit           m_locked;
  logic [W-1:0] hist[$];

  function automatic void find_edge(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] c, output bit hit, output int k);
    bit s[3*W];
    bit ok;
    for (int j = 0; j < W; j++) begin
      s[j]       = a[W-1-j];
      s[W+j]     = b[W-1-j];
      s[2*W+j]   = c[W-1-j];
    end
    hit = 0;
    k   = 0;
    for (int kk = 0; kk < W; kk++) begin
      ok = (s[W+kk-1] == 1'b0);
      for (int m = 0; m < MIN_ONES; m++) ok = ok && s[W+kk+m];
      if (ok && !hit) begin
        hit = 1;
        k   = kk;
      end
    end
  endfunction

  task automatic model_step(input logic rst, input logic [W-1:0] w);
    bit hit;
    int k;
    m_strobe = 0;
    if (rst) begin
      m_mode = 0; m_next = 0; m_conf = 0; m_miss = 0; m_phase = 0;
      m_revo = 0; m_err = 0; m_locked = 0;
      hist.delete();
      repeat (3) hist.push_back('0);
    end else begin
      find_edge(hist[0], hist[1], hist[2], hit, k);
      case (m_mode)
        0: if (hit) begin
          m_phase = k; m_conf = 1; m_next = cyc + P; m_mode = 1;
        end
        1: begin
          if (cyc == m_next && hit && k == m_phase) begin
            m_conf++;
            m_next += P;
            if (m_conf == LOCK_N) begin
              m_mode = 2; m_locked = 1; m_strobe = 1; m_miss = 0;
              m_revo = (m_revo + 1) % 65536;
            end
          end else if (hit) begin
            m_phase = k; m_conf = 1; m_next = cyc + P;
          end else if (cyc == m_next) begin
            m_mode = 0;
          end
        end
        default: begin
          if (cyc == m_next) begin
            m_strobe = 1;
            m_revo   = (m_revo + 1) % 65536;
            m_next  += P;
            if (hit && k == m_phase) begin
              m_miss = 0;
            end else begin
              if (m_err < 65535) m_err++;
              m_miss++;
              if (m_miss == UNLOCK_N) begin
                m_mode = 0; m_locked = 0; m_miss = 0;
              end
            end
          end else if (hit) begin
            if (m_err < 65535) m_err++;
          end
        end
      endcase
      hist.push_back(w);
      void'(hist.pop_front());
    end
    exp_q.push_back({m_strobe, m_locked, 3'(m_phase), 16'(m_revo), 16'(m_err)});
  endtask

  // ---------------------------------------------------------------- checks
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_gaps(input string tag);
    for (int i = 1; i < strobe_ticks.size(); i++)
      check(tag, strobe_ticks[i] - strobe_ticks[i-1], P);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic tick(input logic [W-1:0] w, input logic rst);
    logic [OUT_W-1:0] exp;
    logic [OUT_W-1:0] got;
    word_in = w;
    reset   = rst;
    @(posedge clock);
    model_step(rst, w);
    @(negedge clock);
    exp = exp_q.pop_front();
    got = {revo_strobe, locked, bit_phase, revo_count, error_count};
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL cycle %0d: observed=%h expected=%h", cyc, got, exp);
    end
    if (revo_strobe === 1'b1) strobe_ticks.push_back(cyc);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    repeat (n) tick('0, 1'b1);
    strobe_ticks.delete();
    edge_ticks.delete();
  endtask

  // One revo period of the transmitter pattern at bit phase ph. spur > 0 puts
  // a stray 8'h0F at that word index.
  task automatic run_period(input int ph, input bit present, input int spur, input int len);
    logic [W-1:0] ones;
    logic [W-1:0] w;
    ones = '1;
    for (int i = 0; i < len; i++) begin
      w = '0;
      if (present && i == 0) begin
        w = ones >> ph;
        edge_ticks.push_back(cyc);
      end
      if (present && i == 1 && ph != 0) w = ones << (W - ph);
      if (spur > 0 && i == spur) w = 8'h0F;
      tick(w, 1'b0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_strobe"}, revo_strobe, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_phase"},  bit_phase, 0);
    check({tag, "_revo"},   revo_count, 0);
    check({tag, "_err"},    error_count, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int ph_d;
    int ph_f;
    word_in = '0;
    reset   = 1'b1;

    // reset state
    do_reset(3);
    check_zero("reset");

    // random words: exercises the edge finder and CONFIRM restarts
    for (int i = 0; i < 300; i++) tick(W'($urandom_range(0, 255)), 1'b0);
    do_reset(2);
    check_zero("noise_reset");

    // transmitter pattern, phase 0
    for (int i = 0; i < 6; i++) run_period(0, 1, 0, P);
    check("a_strobes", strobe_ticks.size(), 3);
    check("a_lock_time", strobe_ticks[0], edge_ticks[3] + 2);
    check_gaps("a_gap");
    check("a_locked", locked, 1);
    check("a_phase", bit_phase, 0);
    check("a_err", error_count, 0);
    check("a_revo", revo_count, 3);

    // phase 3, then one miss, a good slot, and three misses
    do_reset(1);
    for (int i = 0; i < 4; i++) run_period(3, 1, 0, P);
    check("b_phase", bit_phase, 3);
    check("b_locked", locked, 1);
    check("b_strobes", strobe_ticks.size(), 1);
    check("b_lock_time", strobe_ticks[0], edge_ticks[3] + 2);
    run_period(3, 0, 0, P);
    check("c_err1", error_count, 1);
    check("c_locked1", locked, 1);
    check("c_strobes1", strobe_ticks.size(), 2);
    run_period(3, 1, 0, P);
    run_period(3, 0, 0, P);
    run_period(3, 0, 0, P);
    check("c_locked2", locked, 1);
    run_period(3, 0, 0, P);
    check("c_locked3", locked, 0);
    check("c_err3", error_count, 4);
    check("c_revo", revo_count, 6);
    check_gaps("c_gap");

    // spurious edge mid-period at a random phase
    ph_d = $urandom_range(0, W - 1);
    do_reset(1);
    for (int i = 0; i < 4; i++) run_period(ph_d, 1, 0, P);
    run_period(ph_d, 1, 600, P);
    run_period(ph_d, 1, 0, P);
    check("d_err", error_count, 1);
    check("d_locked", locked, 1);
    check("d_phase", bit_phase, ph_d);
    check("d_revo", revo_count, 3);
    check("d_strobes", strobe_ticks.size(), 3);
    check_gaps("d_gap");

    // third edge one word early restarts CONFIRM
    do_reset(1);
    run_period(0, 1, 0, P);
    run_period(0, 1, 0, P - 1);
    for (int i = 0; i < 4; i++) run_period(0, 1, 0, P);
    check("e_strobes", strobe_ticks.size(), 1);
    check("e_lock_time", strobe_ticks[0], edge_ticks[5] + 2);
    check("e_locked", locked, 1);
    check("e_err", error_count, 0);

    // one-clock reset while locked, then relock at a random phase
    for (int i = 0; i < 300; i++) tick('0, 1'b0);
    do_reset(1);
    check_zero("f_reset");
    ph_f = $urandom_range(0, W - 1);
    for (int i = 0; i < 5; i++) run_period(ph_f, 1, 0, P);
    check("f_locked", locked, 1);
    check("f_phase", bit_phase, ph_f);
    check("f_strobes", strobe_ticks.size(), 2);
    check("f_lock_time", strobe_ticks[0], edge_ticks[3] + 2);
    check("f_revo", revo_count, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
